freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 192 +++++++++++++++++++
 tb/tb_freq_meter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over a GATE_CYCLES window.
// Define FREQ_METER_PERIOD_EN to add the period_cycles output.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid,
  output logic             overflow
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period_cycles
`endif
);

  localparam int GW =
    (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST =
    GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t state, state_nx;

  logic sync_q1, sync_q2, sync_q3;
  logic edge_pulse;

  logic [GW-1:0]    gate_cnt;
  logic             gate_last;
  logic             gate_clr;
  logic             win_end;
  logic             arm_to;

  logic [CNT_W-1:0] edge_cnt;
  logic             ovf_sticky;
  logic             edge_max;
  logic [CNT_W-1:0] fin_cnt;
  logic             fin_ovf;

  // Two-flop synchronizer plus registered rising-edge detector.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      sync_q3    <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q1    <= sig_in;
      sync_q2    <= sync_q1;
      sync_q3    <= sync_q2;
      edge_pulse <= sync_q2 & ~sync_q3;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_50MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign gate_last = (gate_cnt == GATE_LAST);
  assign busy      = (state != IDLE);

  // Next-state and window control strobes.
  always_comb begin
    state_nx = state;
    gate_clr = 1'b0;
    win_end  = 1'b0;
    arm_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = ARM;
          gate_clr = 1'b1;
        end
      end
      ARM: begin
        if (edge_pulse) begin
          state_nx = MEASURE;
          gate_clr = 1'b1;
        end else if (gate_last) begin
          arm_to   = 1'b1;
          gate_clr = 1'b1;
          state_nx = continuous ? ARM : IDLE;
        end
      end
      MEASURE: begin
        if (gate_last) begin
          win_end  = 1'b1;
          gate_clr = 1'b1;
          state_nx = continuous ? MEASURE : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gate counter: runs in ARM and MEASURE, cleared before it can wrap.
  always_ff @(posedge clk_50MHz) begin
    if (rst)           gate_cnt <= '0;
    else if (gate_clr) gate_cnt <= '0;
    else if (busy)     gate_cnt <= gate_cnt + GW'(1);
  end

  assign edge_max = (edge_cnt == CNT_MAX);
  assign fin_cnt  = (edge_pulse && !edge_max) ?
                    edge_cnt + CNT_W'(1) : edge_cnt;
  assign fin_ovf  = ovf_sticky | (edge_pulse & edge_max);

  // Saturating edge counter with sticky overflow per window.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      edge_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else if (gate_clr) begin
      edge_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else if (state == MEASURE && edge_pulse) begin
      if (edge_max) ovf_sticky <= 1'b1;
      else          edge_cnt   <= edge_cnt + CNT_W'(1);
    end
  end

  // Result registers, updated with a one-cycle valid.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      freq_count <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= win_end | arm_to;
      if (win_end) begin
        freq_count <= fin_cnt;
        overflow   <= fin_ovf;
      end else if (arm_to) begin
        freq_count <= '0;
        overflow   <= 1'b0;
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  // since_cnt == 0 means no edge seen yet in this window.
  logic [CNT_W-1:0] since_cnt;
  logic [CNT_W-1:0] per_cnt;

  // Interval between the last two edge pulses of the window.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      since_cnt     <= '0;
      per_cnt       <= '0;
      period_cycles <= '0;
    end else begin
      if (arm_to) begin
        period_cycles <= '0;
      end else if (win_end) begin
        if (edge_pulse && since_cnt != '0)
          period_cycles <= since_cnt;
        else
          period_cycles <= per_cnt;
      end
      if (state == ARM && edge_pulse) begin
        since_cnt <= CNT_W'(1);
        per_cnt   <= '0;
      end else if (win_end) begin
        since_cnt <= '0;
        per_cnt   <= '0;
      end else if (state == MEASURE) begin
        if (edge_pulse) begin
          if (since_cnt != '0) per_cnt <= since_cnt;
          since_cnt <= CNT_W'(1);
        end else if (since_cnt != '0 &&
                     since_cnt != CNT_MAX) begin
          since_cnt <= since_cnt + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table, random and corner-case checks of freq_meter
// against an edge-time arithmetic model.
module tb_freq_meter;

  localparam int GC = 1000;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        busy, valid, overflow;
  logic [31:0] freq_count;
  logic        busy4, valid4, overflow4;
  logic [3:0]  freq_count4;
`ifdef FREQ_METER_PERIOD_EN
  logic [31:0] period_cycles;
  logic [3:0]  period_cycles4;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int w_t0 = 0;
  int w_p = 0;

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(32)) dut (
`ifdef FREQ_METER_PERIOD_EN
    .period_cycles(period_cycles),
`endif
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .sig_in    (sig_in),
    .start     (start),
    .continuous(continuous),
    .busy      (busy),
    .freq_count(freq_count),
    .valid     (valid),
    .overflow  (overflow)
  );

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(4)) dut4 (
`ifdef FREQ_METER_PERIOD_EN
    .period_cycles(period_cycles4),
`endif
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .sig_in    (sig_in),
    .start     (start),
    .continuous(continuous),
    .busy      (busy4),
    .freq_count(freq_count4),
    .valid     (valid4),
    .overflow  (overflow4)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  // Square wave of period w_p rising at w_t0, w_p+w_t0, ...
  always @(negedge clk_50MHz) begin
    if (w_p > 0 && cyc >= w_t0)
      sig_in = ((cyc - w_t0) % w_p) < (w_p / 2);
    else
      sig_in = 1'b0;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  // Times relative to the cycle start is driven (start sampled at 1).
  // A rise driven at t shows up as an edge pulse at t+3.
  task automatic model(input int t0, input int p, output int vat,
                       output longint cnt, output longint per);
    int s;
    int arm;
    int last;
    int prev;
    s = 1;
    arm = -1;
    cnt = 0;
    per = 0;
    if (p > 0) begin
      for (int k = 0; t0 + k * p + 3 <= s + GC - 1; k++) begin
        if (t0 + k * p + 3 >= s) begin
          arm = t0 + k * p + 3;
          break;
        end
      end
    end
    if (arm < 0) begin
      vat = s + GC;
      return;
    end
    last = arm;
    prev = -1;
    for (int q = arm + p; q <= arm + GC; q += p) begin
      cnt++;
      prev = last;
      last = q;
    end
    per = (prev < 0) ? 0 : last - prev;
    vat = arm + GC + 1;
  endtask

  task automatic wait_valid(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_50MHz);
      if (valid) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic idle_gap();
    w_p = 0;
    repeat (8) @(negedge clk_50MHz);
  endtask

  task automatic run_one(input string nm, input int off,
                         input int p, input longint ecnt,
                         input longint eper);
    int vat;
    int s0;
    int at;
    longint mc;
    longint mp;
    model(off, p, vat, mc, mp);
    @(negedge clk_50MHz);
    s0 = cyc;
    w_t0 = s0 + off;
    w_p = p;
    start = 1'b1;
    @(negedge clk_50MHz);
    start = 1'b0;
    chk({nm, " busy"}, busy, 1);
    wait_valid(vat + 20, at);
    chk({nm, " time"}, at - s0, vat);
    chk({nm, " count"}, freq_count, ecnt);
    chk({nm, " ovf"}, overflow, 0);
    chk({nm, " count4"}, freq_count4, sat4(ecnt));
    chk({nm, " ovf4"}, overflow4, ecnt > 15);
    chk({nm, " valid4"}, valid4, 1);
    chk({nm, " idle"}, busy, 0);
`ifdef FREQ_METER_PERIOD_EN
    chk({nm, " period"}, period_cycles, eper);
    chk({nm, " period4"}, period_cycles4, sat4(eper));
`endif
    @(negedge clk_50MHz);
    chk({nm, " valid1"}, valid, 0);
    idle_gap();
  endtask

  typedef struct {
    int     p;
    longint cnt;
    longint per;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int vat;
    int s0;
    int at;
    int arm;
    int p;
    int off;
    longint mc;
    longint mp;

    tbl[0] = '{p: 10,   cnt: 100, per: 10};
    tbl[1] = '{p: 20,   cnt: 50,  per: 20};
    tbl[2] = '{p: 3,    cnt: 333, per: 3};
    tbl[3] = '{p: 7,    cnt: 142, per: 7};
    tbl[4] = '{p: 1000, cnt: 1,   per: 1000};
    tbl[5] = '{p: 1001, cnt: 0,   per: 0};
    tbl[6] = '{p: 2,    cnt: 500, per: 2};
    tbl[7] = '{p: 0,    cnt: 0,   per: 0};

    repeat (3) @(negedge clk_50MHz);
    rst = 1'b0;
    chk("reset count", freq_count, 0);
    chk("reset valid", valid, 0);
    chk("reset ovf", overflow, 0);
    chk("reset busy", busy, 0);

    @(negedge clk_50MHz);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk_50MHz);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_prio busy", busy, 0);
    @(negedge clk_50MHz);
    chk("rst_prio busy2", busy, 0);

    for (int i = 0; i < 8; i++)
      run_one($sformatf("tbl%0d", i), 5, tbl[i].p,
              tbl[i].cnt, tbl[i].per);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) p = $urandom_range(900, 1100);
      else                           p = $urandom_range(2, 60);
      off = $urandom_range(1, 40);
      model(off, p, vat, mc, mp);
      run_one($sformatf("rnd%0d_p%0d", i, p), off, p, mc, mp);
    end

    model(5, 10, vat, mc, mp);
    @(negedge clk_50MHz);
    s0 = cyc;
    w_t0 = s0 + 5;
    w_p = 10;
    start = 1'b1;
    @(negedge clk_50MHz);
    start = 1'b0;
    while (cyc < s0 + 400) @(negedge clk_50MHz);
    start = 1'b1;
    @(negedge clk_50MHz);
    start = 1'b0;
    wait_valid(vat + 20, at);
    chk("restart_ign time", at - s0, vat);
    chk("restart_ign count", freq_count, 100);
    idle_gap();

    continuous = 1'b1;
    model(5, 20, vat, mc, mp);
    @(negedge clk_50MHz);
    s0 = cyc;
    w_t0 = s0 + 5;
    w_p = 20;
    start = 1'b1;
    @(negedge clk_50MHz);
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) begin
        repeat (500) @(negedge clk_50MHz);
        continuous = 1'b0;
      end
      wait_valid(vat + 20, at);
      chk($sformatf("cont%0d time", j), at - s0, vat + GC * j);
      chk($sformatf("cont%0d count", j), freq_count, 50);
      chk($sformatf("cont%0d count4", j), freq_count4, 15);
      chk($sformatf("cont%0d ovf4", j), overflow4, 1);
      chk($sformatf("cont%0d busy", j), busy, j < 3);
`ifdef FREQ_METER_PERIOD_EN
      chk($sformatf("cont%0d period", j), period_cycles, 20);
`endif
    end
    wait_valid(1500, at);
    chk("cont stop", at, -1);
    idle_gap();

    model(5, 10, vat, mc, mp);
    arm = vat - GC - 1;
    @(negedge clk_50MHz);
    s0 = cyc;
    w_t0 = s0 + 5;
    w_p = 10;
    start = 1'b1;
    @(negedge clk_50MHz);
    start = 1'b0;
    while (cyc < s0 + arm + 500) @(negedge clk_50MHz);
    rst = 1'b1;
    @(negedge clk_50MHz);
    rst = 1'b0;
    chk("rst count", freq_count, 0);
    chk("rst count4", freq_count4, 0);
    chk("rst ovf4", overflow4, 0);
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
`ifdef FREQ_METER_PERIOD_EN
    chk("rst period", period_cycles, 0);
`endif
    wait_valid(1500, at);
    chk("rst no valid", at, -1);
    idle_gap();
    run_one("after_rst", 5, 10, 100, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
